// File: rtl/kv_lookup_table_pkg.sv
// Shared constants and FSM encoding for the key/value lookup table.
// Default widths match the xport2user UDP port demux.
package kv_lookup_table_pkg;

   localparam int DEF_KEY_W = 16;
   localparam int DEF_VAL_W = 112;
   localparam int DEF_SIZE  = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      INS_SCAN  = 2'd1,
      INS_WRITE = 2'd2,
      FIND_SCAN = 2'd3
   } kv_state_t;

endpackage

// File: rtl/kv_lookup_table_entry_cmp.sv
// Single-entry comparator: an entry hits when it is valid and its stored key
// equals the key under search on all KEY_W bits.
module kv_entry_cmp
   import kv_lookup_table_pkg::*;
#(
   parameter int KEY_W = DEF_KEY_W
) (
   input  logic             valid,
   input  logic [KEY_W-1:0] entry_key,
   input  logic [KEY_W-1:0] key,
   output logic             hit
);

   assign hit = valid && (entry_key == key);

endmodule

// File: rtl/kv_lookup_table.sv
// Register-based key/value table with sequential one-entry-per-cycle scanning
// for insert/update (with round-robin eviction) and lookup.
module kv_lookup_table
   import kv_lookup_table_pkg::*;
#(
   parameter int KEY_W = DEF_KEY_W,
   parameter int VAL_W = DEF_VAL_W,
   parameter int SIZE  = DEF_SIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             insert_key_stb,
   input  logic [KEY_W-1:0] insert_key,
   input  logic [VAL_W-1:0] insert_value,
   input  logic             find_key_stb,
   input  logic [KEY_W-1:0] find_key,
   output logic             kv_map_busy,
   output logic             find_res_stb,
   output logic             find_res_match,
   output logic [VAL_W-1:0] find_res_value,
   output logic [SIZE:0]    occupied
);

   localparam int N = 1 << SIZE;

   kv_state_t        state;
   kv_state_t        next_state;

   logic [N-1:0]     valid;
   logic [KEY_W-1:0] keys [N];
   logic [VAL_W-1:0] vals [N];

   logic [SIZE-1:0]  idx;
   logic             last_idx;
   logic [KEY_W-1:0] scan_key;
   logic [VAL_W-1:0] ins_value;
   logic             pend_find;
   logic [KEY_W-1:0] pend_key;

   logic             have_match;
   logic [SIZE-1:0]  match_idx;
   logic             have_free;
   logic [SIZE-1:0]  free_idx;
   logic [SIZE-1:0]  repl_ptr;

   logic [SIZE-1:0]  wr_idx;
   logic             wr_new;
   logic             wr_evict;
   logic             hit;

   assign last_idx = (idx == SIZE'(N - 1));

   kv_entry_cmp #(
      .KEY_W(KEY_W)
   ) u_cmp (
      .valid     (valid[idx]),
      .entry_key (keys[idx]),
      .key       (scan_key),
      .hit       (hit)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (insert_key_stb)
               next_state = INS_SCAN;
            else if (find_key_stb)
               next_state = FIND_SCAN;
         end
         INS_SCAN: begin
            if (last_idx)
               next_state = INS_WRITE;
         end
         INS_WRITE: begin
            next_state = pend_find ? FIND_SCAN : IDLE;
         end
         FIND_SCAN: begin
            if (hit || last_idx)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Write target: existing key first, then lowest free slot, then evict.
   always_comb begin
      wr_idx   = repl_ptr;
      wr_new   = 1'b0;
      wr_evict = 1'b0;
      if (have_match) begin
         wr_idx = match_idx;
      end else if (have_free) begin
         wr_idx = free_idx;
         wr_new = 1'b1;
      end else begin
         wr_evict = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         kv_map_busy    <= 1'b0;
         valid          <= '0;
         occupied       <= '0;
         repl_ptr       <= '0;
         pend_find      <= 1'b0;
         find_res_stb   <= 1'b0;
         find_res_match <= 1'b0;
         find_res_value <= '0;
         idx            <= '0;
         have_match     <= 1'b0;
         have_free      <= 1'b0;
      end else begin
         state        <= next_state;
         kv_map_busy  <= (next_state != IDLE);
         find_res_stb <= 1'b0;
         case (state)
            IDLE: begin
               idx        <= '0;
               have_match <= 1'b0;
               have_free  <= 1'b0;
               pend_find  <= insert_key_stb && find_key_stb;
            end
            INS_SCAN: begin
               idx <= idx + SIZE'(1);
               if (hit && !have_match) begin
                  have_match <= 1'b1;
                  match_idx  <= idx;
               end
               if (!valid[idx] && !have_free) begin
                  have_free <= 1'b1;
                  free_idx  <= idx;
               end
            end
            INS_WRITE: begin
               valid[wr_idx] <= 1'b1;
               if (wr_new)
                  occupied <= occupied + (SIZE + 1)'(1);
               if (wr_evict)
                  repl_ptr <= repl_ptr + SIZE'(1);
               pend_find <= 1'b0;
               idx       <= '0;
            end
            FIND_SCAN: begin
               idx <= idx + SIZE'(1);
               if (hit || last_idx) begin
                  find_res_stb   <= 1'b1;
                  find_res_match <= hit;
                  find_res_value <= hit ? vals[idx] : '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Key/value storage and request latches carry no reset; valid gates them.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (insert_key_stb) begin
            scan_key  <= insert_key;
            ins_value <= insert_value;
            pend_key  <= find_key;
         end else if (find_key_stb) begin
            scan_key <= find_key;
         end
      end
      if (state == INS_WRITE && !rst) begin
         keys[wr_idx] <= scan_key;
         vals[wr_idx] <= ins_value;
         if (pend_find)
            scan_key <= pend_key;
      end
   end

endmodule

// File: tb/tb_kv_lookup_table.sv
// Randomised bench for kv_lookup_table against a slot-level table model.
module tb_kv_lookup_table;

   localparam int KEY_W = 16;
   localparam int VAL_W = 112;
   localparam int SIZE  = 4;
   localparam int N     = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             insert_key_stb;
   logic [KEY_W-1:0] insert_key;
   logic [VAL_W-1:0] insert_value;
   logic             find_key_stb;
   logic [KEY_W-1:0] find_key;
   logic             kv_map_busy;
   logic             find_res_stb;
   logic             find_res_match;
   logic [VAL_W-1:0] find_res_value;
   logic [SIZE:0]    occupied;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   kv_lookup_table #(.KEY_W(KEY_W), .VAL_W(VAL_W), .SIZE(SIZE)) dut (
      .clk            (clk),
      .rst            (rst),
      .insert_key_stb (insert_key_stb),
      .insert_key     (insert_key),
      .insert_value   (insert_value),
      .find_key_stb   (find_key_stb),
      .find_key       (find_key),
      .kv_map_busy    (kv_map_busy),
      .find_res_stb   (find_res_stb),
      .find_res_match (find_res_match),
      .find_res_value (find_res_value),
      .occupied       (occupied)
   );

   // Reference table: slot contents, eviction pointer and count.
   logic             mv   [N];
   logic [KEY_W-1:0] mk   [N];
   logic [VAL_W-1:0] mval [N];
   int               mptr;
   int               mocc;

   task automatic m_clear();
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
      mptr = 0;
      mocc = 0;
   endtask

   task automatic m_insert(input logic [KEY_W-1:0] key, input logic [VAL_W-1:0] val);
      int slot = -1;
      for (int i = 0; i < N; i++)
         if (slot < 0 && mv[i] && mk[i] == key) slot = i;
      for (int i = 0; i < N; i++)
         if (slot < 0 && !mv[i]) begin
            slot = i;
            mocc++;
         end
      if (slot < 0) begin
         slot = mptr;
         mptr = (mptr + 1) % N;
      end
      mv[slot]   = 1'b1;
      mk[slot]   = key;
      mval[slot] = val;
   endtask

   // Returns slot index or -1, plus expected strobe latency and result value.
   task automatic m_find(input logic [KEY_W-1:0] key, output int slot, output int lat,
                         output logic [VAL_W-1:0] val);
      slot = -1;
      for (int i = 0; i < N; i++)
         if (slot < 0 && mv[i] && mk[i] == key) slot = i;
      lat = (slot < 0) ? N + 1 : slot + 2;
      val = (slot < 0) ? '0 : mval[slot];
   endtask

   function automatic logic [VAL_W-1:0] mkval(input logic [KEY_W-1:0] key);
      return {key, $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_clear();
   endtask

   task automatic do_insert(input logic [KEY_W-1:0] key, input logic [VAL_W-1:0] val,
                            output int busy_cnt);
      insert_key = key;
      insert_value = val;
      insert_key_stb = 1'b1;
      @(posedge clk); #1;
      insert_key_stb = 1'b0;
      busy_cnt = 0;
      while (kv_map_busy && busy_cnt < 60) begin
         busy_cnt++;
         @(posedge clk); #1;
      end
      m_insert(key, val);
   endtask

   // Launch a find (optionally with an insert in the same cycle) and wait for the result.
   task automatic do_find(input logic with_ins, input logic [KEY_W-1:0] ikey,
                          input logic [VAL_W-1:0] ival, input logic [KEY_W-1:0] key,
                          input logic poke_busy, output int lat, output logic m,
                          output logic [VAL_W-1:0] v, output int busy_cnt,
                          output logic busy_at_res);
      insert_key = ikey;
      insert_value = ival;
      insert_key_stb = with_ins;
      find_key = key;
      find_key_stb = 1'b1;
      @(posedge clk); #1;
      insert_key_stb = 1'b0;
      find_key_stb = 1'b0;
      lat = 0;
      m = 1'bx;
      v = 'x;
      busy_cnt = 0;
      busy_at_res = 1'bx;
      for (int k = 1; k <= 60; k++) begin
         if (find_res_stb) begin
            lat = k;
            m = find_res_match;
            v = find_res_value;
            busy_at_res = kv_map_busy;
            break;
         end
         if (kv_map_busy) busy_cnt++;
         find_key_stb = poke_busy && (k == 5);
         find_key = poke_busy ? 16'h7777 : key;
         @(posedge clk); #1;
         find_key_stb = 1'b0;
      end
      if (with_ins) m_insert(ikey, ival);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (kv_map_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", kv_map_busy); end
      total++; if (find_res_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b want=0", find_res_stb); end
      total++; if (find_res_match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b want=0", find_res_match); end
      total++; if (find_res_value !== '0) begin bad++; $display("FAIL reset_value got=%h want=0", find_res_value); end
      total++; if (occupied !== '0) begin bad++; $display("FAIL reset_occupied got=%0d want=0", occupied); end
      rst = 1'b0;
      m_clear();
   endtask

   task automatic test_find_empty();
      int lat, bc; logic m, br; logic [VAL_W-1:0] v;
      do_find(1'b0, '0, '0, 16'h1234, 1'b0, lat, m, v, bc, br);
      total++; if (lat !== N + 1) begin bad++; $display("FAIL empty_lat got=%0d want=%0d", lat, N + 1); end
      total++; if (m !== 1'b0) begin bad++; $display("FAIL empty_match got=%b want=0", m); end
      total++; if (v !== '0) begin bad++; $display("FAIL empty_value got=%h want=0", v); end
      total++; if (bc !== N) begin bad++; $display("FAIL empty_busy got=%0d want=%0d", bc, N); end
      total++; if (br !== 1'b0) begin bad++; $display("FAIL empty_busy_at_res got=%b want=0", br); end
   endtask

   task automatic test_insert_find();
      int lat, bc; logic m, br; logic [VAL_W-1:0] v, v1;
      v1 = mkval(16'h1388);
      do_insert(16'h1388, v1, bc);
      total++; if (bc !== N + 1) begin bad++; $display("FAIL ins_busy got=%0d want=%0d", bc, N + 1); end
      total++; if (occupied !== 5'd1) begin bad++; $display("FAIL ins_occupied got=%0d want=1", occupied); end
      do_find(1'b0, '0, '0, 16'h1388, 1'b0, lat, m, v, bc, br);
      total++; if (lat !== 2) begin bad++; $display("FAIL ins_find_lat got=%0d want=2", lat); end
      total++; if (m !== 1'b1) begin bad++; $display("FAIL ins_find_match got=%b want=1", m); end
      total++; if (v !== v1) begin bad++; $display("FAIL ins_find_value got=%h want=%h", v, v1); end
      @(posedge clk); #1;
      total++; if (find_res_stb !== 1'b0) begin bad++; $display("FAIL stb_one_cycle got=%b want=0", find_res_stb); end
      total++; if (find_res_value !== v1) begin bad++; $display("FAIL value_hold got=%h want=%h", find_res_value, v1); end
   endtask

   task automatic test_update();
      int lat, bc; logic m, br; logic [VAL_W-1:0] v, v2;
      v2 = mkval(16'h1388);
      do_insert(16'h1388, v2, bc);
      total++; if (occupied !== 5'd1) begin bad++; $display("FAIL upd_occupied got=%0d want=1", occupied); end
      do_find(1'b0, '0, '0, 16'h1388, 1'b0, lat, m, v, bc, br);
      total++; if (m !== 1'b1 || v !== v2) begin bad++; $display("FAIL upd_value got=%b/%h want=1/%h", m, v, v2); end
   endtask

   task automatic test_eviction();
      int lat, bc, slot, elat; logic m, br; logic [VAL_W-1:0] v, ev;
      logic [KEY_W-1:0] k;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         k = KEY_W'(i * 16'h0111);
         do_insert(k, mkval(k), bc);
      end
      total++; if (occupied !== 5'd16) begin bad++; $display("FAIL fill_occupied got=%0d want=16", occupied); end
      do_insert(16'hBEEF, mkval(16'hBEEF), bc);
      total++; if (occupied !== 5'd16) begin bad++; $display("FAIL evict_occupied got=%0d want=16", occupied); end
      do_find(1'b0, '0, '0, 16'h0000, 1'b0, lat, m, v, bc, br);
      total++; if (m !== 1'b0 || lat !== N + 1) begin bad++; $display("FAIL evict_first got=%b/%0d want=0/%0d", m, lat, N + 1); end
      m_find(16'hBEEF, slot, elat, ev);
      do_find(1'b0, '0, '0, 16'hBEEF, 1'b0, lat, m, v, bc, br);
      total++; if (lat !== 2 || m !== 1'b1 || v !== ev) begin bad++; $display("FAIL evict_new got=%0d/%b/%h want=2/1/%h", lat, m, v, ev); end
      do_insert(16'hCAFE, mkval(16'hCAFE), bc);
      do_find(1'b0, '0, '0, 16'h0111, 1'b0, lat, m, v, bc, br);
      total++; if (m !== 1'b0) begin bad++; $display("FAIL evict_second got=%b want=0", m); end
      do_find(1'b0, '0, '0, 16'hCAFE, 1'b0, lat, m, v, bc, br);
      total++; if (lat !== 3 || m !== 1'b1) begin bad++; $display("FAIL evict_ptr got=%0d/%b want=3/1", lat, m); end
   endtask

   task automatic test_simultaneous();
      int lat, bc, slot, elat, extra; logic m, br; logic [VAL_W-1:0] v, v3, ev;
      v3 = mkval(16'h2000);
      do_find(1'b1, 16'h2000, v3, 16'h2000, 1'b1, lat, m, v, bc, br);
      m_find(16'h2000, slot, elat, ev);
      total++; if (lat !== N + 1 + elat) begin bad++; $display("FAIL sim_lat got=%0d want=%0d", lat, N + 1 + elat); end
      total++; if (m !== 1'b1 || v !== v3) begin bad++; $display("FAIL sim_result got=%b/%h want=1/%h", m, v, v3); end
      total++; if (bc !== lat - 1) begin bad++; $display("FAIL sim_busy got=%0d want=%0d", bc, lat - 1); end
      extra = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (find_res_stb || kv_map_busy) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL sim_ignored got=%0d want=0", extra); end
   endtask

   task automatic test_reset_mid();
      int lat, bc; logic m, br; logic [VAL_W-1:0] v;
      do_insert(16'h5151, mkval(16'h5151), bc);
      insert_key = 16'h4242;
      insert_value = mkval(16'h4242);
      insert_key_stb = 1'b1;
      @(posedge clk); #1;
      insert_key_stb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_clear();
      total++; if (occupied !== '0 || kv_map_busy !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%0d/%b want=0/0", occupied, kv_map_busy); end
      do_find(1'b0, '0, '0, 16'h4242, 1'b0, lat, m, v, bc, br);
      total++; if (m !== 1'b0 || lat !== N + 1) begin bad++; $display("FAIL rstmid_find got=%b/%0d want=0/%0d", m, lat, N + 1); end
      do_find(1'b0, '0, '0, 16'h5151, 1'b0, lat, m, v, bc, br);
      total++; if (m !== 1'b0) begin bad++; $display("FAIL rstmid_old got=%b want=0", m); end
   endtask

   task automatic test_random();
      int lat, bc, slot, elat, op; logic m, br; logic [VAL_W-1:0] v, ev, iv;
      logic [KEY_W-1:0] ik, fk;
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 2);
         ik = KEY_W'($urandom_range(0, 22) * 16'h0101);
         fk = ($urandom_range(0, 3) == 0) ? ik : KEY_W'($urandom_range(0, 22) * 16'h0101);
         iv = mkval(ik);
         if (op == 0) begin
            do_insert(ik, iv, bc);
            total++; if (bc !== N + 1) begin bad++; $display("FAIL rnd_ins_busy n=%0d got=%0d want=%0d", n, bc, N + 1); end
         end else begin
            do_find(op == 2, ik, iv, fk, 1'b0, lat, m, v, bc, br);
            m_find(fk, slot, elat, ev);
            if (op == 2) elat = elat + N + 1;
            total++;
            if (lat !== elat || m !== (slot >= 0) || v !== ev) begin
               bad++;
               $display("FAIL rnd_find n=%0d key=%h got=%0d/%b/%h want=%0d/%b/%h", n, fk, lat, m, v, elat, slot >= 0, ev);
            end
         end
         total++; if (occupied !== (SIZE + 1)'(mocc)) begin bad++; $display("FAIL rnd_occupied n=%0d got=%0d want=%0d", n, occupied, mocc); end
      end
   endtask

   initial begin
      rst = 1'b1;
      insert_key_stb = 1'b0;
      insert_key = '0;
      insert_value = '0;
      find_key_stb = 1'b0;
      find_key = '0;
      m_clear();
      test_reset();
      test_find_empty();
      test_insert_find();
      test_update();
      test_eviction();
      test_simultaneous();
      test_reset_mid();
      apply_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kv_lookup_table.md
KV_LOOKUP_TABLE -- requirements
Module: kv_lookup_table

Interface
REQ-001 Parameter KEY_W, default 16, key width (UDP port).
REQ-002 Parameter VAL_W, default 112, value width; key occupies value[VAL_W-1 -: KEY_W].
REQ-003 Parameter SIZE, default 4, table depth N = 2^SIZE entries.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 insert_key_stb  input  1  one-cycle insert/update request.
REQ-007 insert_key  input  KEY_W  key to insert.
REQ-008 insert_value  input  VAL_W  value to store.
REQ-009 find_key_stb  input  1  one-cycle lookup request.
REQ-010 find_key  input  KEY_W  key to look up.
REQ-011 kv_map_busy  output  1  table operation in progress; requests ignored while high.
REQ-012 find_res_stb  output  1  one-cycle lookup result strobe.
REQ-013 find_res_match  output  1  key found; valid only with find_res_stb.
REQ-014 find_res_value  output  VAL_W  stored value on match, 0 on miss; valid only with find_res_stb.
REQ-015 occupied  output  SIZE+1  count of valid entries, 0..N.

Function
REQ-016 Storage: N entries of {valid, key, value}; registers, no block RAM.
REQ-017 FSM states IDLE, INS_SCAN, INS_WRITE, FIND_SCAN; kv_map_busy = (state != IDLE), registered.
REQ-018 Requests are sampled only in IDLE; strobes arriving while busy are ignored, no state change.
REQ-019 IDLE + insert_key_stb at cycle T: latch key/value, scan index 0 -> INS_SCAN at T+1.
REQ-020 INS_SCAN compares one entry per cycle, index 0..N-1; records first valid key match and first invalid index.
REQ-021 After index N-1 -> INS_WRITE; write target priority: matching entry (value overwrite), else lowest invalid entry, else entry at replacement pointer.
REQ-022 Replacement pointer: SIZE bits, round-robin, increments (wrapping N-1 -> 0) only when a full-table eviction occurs.
REQ-023 INS_WRITE writes target entry, sets valid, returns to IDLE; insert busy span exactly N+1 cycles (T+1..T+N+1).
REQ-024 occupied increments only when an invalid entry is written; unchanged on update or eviction.
REQ-025 IDLE + find_key_stb (no insert) at cycle T: latch key, FIND_SCAN from index 0 at T+1.
REQ-026 FIND_SCAN stops at first valid match at index i: find_res_stb=1, match=1, value=entry value at cycle T+2+i; IDLE same cycle.
REQ-027 No match after index N-1: find_res_stb=1, match=0, value=0 at cycle T+N+1; IDLE same cycle.
REQ-028 Simultaneous insert_key_stb and find_key_stb in IDLE: insert executes first; find key latched as pending; FIND_SCAN starts the cycle after INS_WRITE without releasing busy; lookup sees the newly written entry.
REQ-029 find_res_stb is exactly one cycle; find_res_match/find_res_value hold until next strobe.
REQ-030 Keys compared on full KEY_W bits; key 0 is a legal key.

Reset
REQ-031 On rst: state IDLE, all valid bits 0, occupied 0, replacement pointer 0, pending find cleared, kv_map_busy 0, find_res_stb 0, find_res_match 0, find_res_value 0.
REQ-032 rst mid-operation aborts scan/write with no entry modified in that cycle; no result strobe issued.
REQ-033 Key/value storage arrays need no reset; valid bits gate all use.

Structure
REQ-034 Shared package holds FSM state encodings and default KEY_W/VAL_W/SIZE constants shared with xport2user.
REQ-035 Single module; one natural sub-module kv_entry_cmp (per-index valid+key compare) is permitted, no other hierarchy.

Verification
REQ-036 Reset, find key 0x1234 -> find_res_stb at T+N+1=T+17, match=0, value=0, busy high T+1..T+16.
REQ-037 Insert 0x1388/V1, then find 0x1388 -> match=1, value=V1 at T+2; occupied=1.
REQ-038 Insert 0x1388/V1 then 0x1388/V2 -> occupied stays 1; find returns V2.
REQ-039 Fill 16 distinct keys, insert 17th key 0xBEEF -> entry 0 evicted (find of first key misses), pointer=1, occupied=16; 18th insert evicts entry 1.
REQ-040 Same-cycle insert 0x2000/V3 and find 0x2000 -> busy continuous, find_res_stb match=1 value=V3; find strobe while busy produces no result.
REQ-041 Assert rst during INS_SCAN -> occupied=0, busy=0 next cycle, subsequent find misses.
